approx_wallace_dot_accumulator: RTL
===================================

# approx_wallace_dot_accumulator

Operand sequencer and product accumulator placed around the approximate 8-bit Wallace-tree multiplier top. It accepts VEC_LEN operand pairs over a valid/ready handshake and drives them onto the multiplier's A/B inputs. It tracks each product through the multiplier's registered latency and sums the 16-bit products into an ACC_W-bit accumulator. The finished dot product is presented on a valid/ready result port.

## Interface
- VEC_LEN, 8: operand pairs per dot product; range 1..256.
- ACC_W, 24: accumulator width; must satisfy ACC_W ≥ 16.
- MULT_LAT, 2: clock edges from operand capture to product valid on mult_s; must satisfy MULT_LAT ≥ 1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new dot product; sampled only in IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair.
- a_in, b_in  in  8 each  unsigned operands.
- mult_a, mult_b  out  8 each  to the multiplier's A_in/B_in.
- mult_s  in  16  from the multiplier's S_out.
- acc_out  out  ACC_W  accumulated sum.
- out_valid  out  1  acc_out holds the final result.
- out_ready  in  1  consumer takes the result.
- busy  out  1  high in every state except IDLE.
- overflow  out  1  sticky flag: accumulator exceeded 2^ACC_W−1 during the current run.

## Operation
- The block has four states: IDLE, RUN, DRAIN, DONE.
- IDLE
  - in_ready=0, out_valid=0, busy=0.
  - When start=1: clear acc, count, and overflow, then go to RUN.
- RUN
  - in_ready=1.
  - Accept on in_valid & in_ready, then count += 1.
  - When the accept makes count==VEC_LEN, go to DRAIN.
- DRAIN
  - in_ready=0.
  - Go to DONE on the edge that performs the last accumulate: the shift-register tail bit is 1 and all other shift-register bits are 0.
- DONE
  - out_valid=1 and acc_out is stable.
  - When out_ready=1: go to IDLE. out_valid drops the next cycle.
- start is ignored in every state except IDLE.
- mult_a/mult_b equal a_in/b_in combinationally while in RUN; otherwise they are 0.
- Product tracking uses a valid shift register sr[MULT_LAT-1:0]:
  - sr[0] is loaded with the accept bit each edge; the register shifts every edge.
  - When sr[MULT_LAT-1]=1, acc ← acc + zero-extended mult_s.
  - Each accepted pair is therefore summed exactly once, MULT_LAT edges after its accept edge.
- Arithmetic is unsigned. acc_out is the acc register directly.
- The multiplier has no reset. Stale values on mult_s are never summed because sr is cleared by reset and by start.
- Reset mid-operation: all registers clear immediately (see Timing). In-flight products are discarded.

## Timing
- Reset values:
  - state=IDLE; acc_out, count, and sr are 0.
  - out_valid=0, overflow=0, busy=0, in_ready=0.
  - mult_a=0, mult_b=0.
- start sampled at edge t → RUN, with in_ready=1, from after edge t.
- The last accept at edge k gives the final accumulate at edge k+MULT_LAT. out_valid=1 from after that same edge.
- Back-to-back throughput: one pair per cycle. Bubbles (in_valid=0) stall count only; in-flight products continue.
- Result handshake: out_valid is held with acc_out unchanged until the edge where out_ready=1.

## Configuration
- SATURATE_EN defined:
  - If acc + mult_s exceeds 2^ACC_W−1, acc clamps to 2^ACC_W−1 and overflow sets.
  - Later additions keep acc clamped.
- SATURATE_EN undefined:
  - acc wraps modulo 2^ACC_W.
  - overflow sets on any carry-out from the ACC_W-bit add.
- In both builds overflow is sticky until start or rst.

## Test plan
- The bench uses an exact behavioural multiplier stub with MULT_LAT=2 in place of the approximate tree.
- Basic dot product: VEC_LEN=4, back-to-back pairs (1,1), (2,3), (255,255), (10,0) accepted at edges 1–4 → acc_out=65032 and out_valid=1 after edge 6; overflow=0.
- Bubbles: same pairs with in_valid low for 2 cycles between each pair → acc_out=65032 and out_valid=1 two edges after the 4th accept; count never exceeds 4.
- Overflow: ACC_W=16, VEC_LEN=2, pairs (255,255)×2 → with SATURATE_EN, acc_out=65535 and overflow=1; without it, acc_out=64514 and overflow=1.
- Reset mid-RUN: rst pulsed after the 2nd accept → all outputs return to reset values immediately. A following start plus 4 fresh pairs produces the correct sum with no stale contribution.
- Result backpressure: out_ready held low 5 cycles in DONE while start=1 → out_valid and acc_out remain stable and no new run starts. out_ready=1 → IDLE next edge. The next start is then accepted.

Source files
------------

// File: rtl/approx_wallace_dot_accumulator.sv
// Operand sequencer and product accumulator around the approximate multiplier.
// Build option: define SATURATE_EN to clamp the accumulator instead of wrapping.
module approx_wallace_dot_accumulator #(
  parameter int VEC_LEN  = 8,
  parameter int ACC_W    = 24,
  parameter int MULT_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  output logic [7:0]       mult_a,
  output logic [7:0]       mult_b,
  input  logic [15:0]      mult_s,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int CW = $clog2(VEC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);
  localparam logic [MULT_LAT-1:0] TAIL =
    MULT_LAT'(1) << (MULT_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_count;
  logic [MULT_LAT-1:0] r_sr;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;

  logic                w_accept;
  logic [ACC_W:0]      w_prod;
  logic [ACC_W:0]      w_sum;
  logic                w_carry;
  logic [ACC_W-1:0]    w_acc_add;

  assign w_accept = in_valid & in_ready;
  assign w_prod   = {{(ACC_W + 1 - 16){1'b0}}, mult_s};
  assign w_sum    = {1'b0, r_acc} + w_prod;
  assign w_carry  = w_sum[ACC_W];

`ifdef SATURATE_EN
  assign w_acc_add = w_carry ? {ACC_W{1'b1}}
                             : w_sum[ACC_W-1:0];
`else
  assign w_acc_add = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mult_a    = '0;
    mult_b    = '0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        mult_a   = a_in;
        mult_b   = b_in;
        if (in_valid && r_count == LAST)
          w_next = DRAIN;
      end
      // last product is in the tail with nothing behind it
      DRAIN: begin
        if (r_sr == TAIL) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_sr    <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_count <= '0;
        r_sr    <= '0;
        r_acc   <= '0;
        r_ovf   <= 1'b0;
      end else begin
        r_sr <= (r_sr << 1) | MULT_LAT'(w_accept);
        if (w_accept)
          r_count <= r_count + CW'(1);
        if (r_sr[MULT_LAT-1]) begin
          r_acc <= w_acc_add;
          if (w_carry) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign acc_out  = r_acc;
  assign overflow = r_ovf;

endmodule
